// File: rtl/regwrite_arbiter.sv
// Two-requester register-file write arbiter.
// Each requester owns a small FIFO of {reg, data} entries. One head per cycle
// is granted (round-robin on a tie), dequeued, and registered onto the
// register-file write port. Writes to x31 are consumed but never issued.

// Per-requester FIFO; a pop and a push may land on the same edge.
module regwrite_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 69
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  // Full/empty come from the stored count only, so a same-cycle pop never
  // opens a slot for a push when the FIFO is full.
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and count next state; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (do_pop)  rptr_d = rptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/count state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the count masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end
endmodule

module regwrite_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        AValid,
  input  logic [4:0]  AReg,
  input  logic [63:0] AData,
  output logic        AReady,
  input  logic        BValid,
  input  logic [4:0]  BReg,
  input  logic [63:0] BData,
  output logic        BReady,
  input  logic        Stall,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [63:0] WriteData,
  output logic        Busy
);
  localparam int NREQ = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_req_t;

  localparam int EW = $bits(wr_req_t);

  // Index 0 is requester A, index 1 is requester B.
  logic    [NREQ-1:0] vld, full, empty, pop;
  wr_req_t [NREQ-1:0] req, head;

  logic        grant_vld;
  logic        grant_sel;
  logic        last_q, last_d;          // 0 = A granted last, 1 = B
  logic        regwrite_q, regwrite_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [63:0] wdata_q, wdata_d;

  assign vld[0]      = AValid;
  assign vld[1]      = BValid;
  assign req[0].rd   = AReg;
  assign req[0].data = AData;
  assign req[1].rd   = BReg;
  assign req[1].data = BData;

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_fifo
      regwrite_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (vld[g]),
        .din_i   (req[g]),
        .pop_i   (pop[g]),
        .dout_o  (head[g]),
        .empty_o (empty[g]),
        .full_o  (full[g])
      );
    end
  endgenerate

  assign AReady = ~full[0];
  assign BReady = ~full[1];

  // Pick one head: the only non-empty FIFO, or on a tie the one not granted last.
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    if (!Stall) begin
      if (!empty[0] && !empty[1]) begin
        grant_vld = 1'b1;
        grant_sel = ~last_q;
      end else if (!empty[0]) begin
        grant_vld = 1'b1;
        grant_sel = 1'b0;
      end else if (!empty[1]) begin
        grant_vld = 1'b1;
        grant_sel = 1'b1;
      end
    end
  end

  assign pop = grant_vld ? (NREQ'(1) << grant_sel) : '0;

  // Write-port next state; x31 entries are consumed with the enable held low.
  always_comb begin
    last_d     = last_q;
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    if (grant_vld) begin
      last_d     = grant_sel;
      wreg_d     = head[grant_sel].rd;
      wdata_d    = head[grant_sel].data;
      regwrite_d = (head[grant_sel].rd != 5'd31);
    end
  end

  // Registered write port and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= 1'b1;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      last_q     <= last_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  assign RegWrite      = regwrite_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign Busy          = (|(~empty)) | regwrite_q;
endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter with a small register-file model on the
// write port.
module tb_regwrite_arbiter;
  localparam int DEPTH = 2;

  logic        clk, rst_n;
  logic        AValid, BValid, AReady, BReady, Stall;
  logic [4:0]  AReg, BReg, WriteRegister;
  logic [63:0] AData, BData, WriteData;
  logic        RegWrite, Busy;

  int total = 0;
  int bad   = 0;

  logic [63:0] rf [32];

  regwrite_arbiter #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .AValid        (AValid),
    .AReg          (AReg),
    .AData         (AData),
    .AReady        (AReady),
    .BValid        (BValid),
    .BReg          (BReg),
    .BData         (BData),
    .BReady        (BReady),
    .Stall         (Stall),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .Busy          (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: commits the write port on the edge after it is presented.
  always @(posedge clk) begin
    if (RegWrite && WriteRegister != 5'd0) rf[WriteRegister] <= WriteData;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 || WriteData !== 64'd0) begin
      bad++;
      $display("FAIL reset_port: got we=%b reg=%0d data=%h want 0/0/0", RegWrite, WriteRegister, WriteData);
    end
    total++;
    if (Busy !== 1'b0 || AReady !== 1'b1 || BReady !== 1'b1) begin
      bad++;
      $display("FAIL reset_flags: got busy=%b ar=%b br=%b want 0/1/1", Busy, AReady, BReady);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_tie();
    AValid = 1; AReg = 5'd3; AData = 64'h11;
    BValid = 1; BReg = 5'd4; BData = 64'h22;
    tick();
    AValid = 0; BValid = 0;
    total++;
    if (RegWrite !== 1'b0 || Busy !== 1'b1) begin
      bad++;
      $display("FAIL tie_enq: got we=%b busy=%b want 0/1", RegWrite, Busy);
    end
    tick();
    total++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd3 || WriteData !== 64'h11) begin
      bad++;
      $display("FAIL tie_first: got we=%b reg=%0d data=%h want 1/3/11", RegWrite, WriteRegister, WriteData);
    end
    tick();
    total++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd4 || WriteData !== 64'h22) begin
      bad++;
      $display("FAIL tie_second: got we=%b reg=%0d data=%h want 1/4/22", RegWrite, WriteRegister, WriteData);
    end
    tick();
    total++;
    if (RegWrite !== 1'b0 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL tie_idle: got we=%b busy=%b want 0/0", RegWrite, Busy);
    end
  endtask

  task automatic test_fairness();
    int ai = 0, bi = 0, wc = 0, first = -1, last = -1;
    logic ar, br;
    logic [4:0]  ereg;
    logic [63:0] edata;
    for (int cyc = 0; cyc < 40; cyc++) begin
      AValid = (ai < 8); AReg = 5'(ai + 1);  AData = 64'hA000 + 64'(ai);
      BValid = (bi < 8); BReg = 5'(bi + 16); BData = 64'hB000 + 64'(bi);
      ar = AReady; br = BReady;
      tick();
      if (AValid && ar) ai++;
      if (BValid && br) bi++;
      if (RegWrite) begin
        if (wc % 2 == 0) begin
          ereg = 5'(wc / 2 + 1);  edata = 64'hA000 + 64'(wc / 2);
        end else begin
          ereg = 5'(wc / 2 + 16); edata = 64'hB000 + 64'(wc / 2);
        end
        total++;
        if (WriteRegister !== ereg || WriteData !== edata) begin
          bad++;
          $display("FAIL fair_write%0d: got reg=%0d data=%h want reg=%0d data=%h", wc, WriteRegister, WriteData, ereg, edata);
        end
        if (first < 0) first = cyc;
        last = cyc;
        wc++;
      end
    end
    AValid = 0; BValid = 0;
    total++;
    if (wc !== 16 || (last - first) !== 15) begin
      bad++;
      $display("FAIL fair_count: got writes=%0d span=%0d want 16/15", wc, last - first);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic ar;
    Stall = 1;
    for (int i = 0; i <= DEPTH; i++) begin
      AValid = 1; AReg = 5'd7; AData = 64'hC0 + 64'(acc);
      total++;
      if (AReady !== (i < DEPTH)) begin
        bad++;
        $display("FAIL bp_ready%0d: got %b want %b", i, AReady, (i < DEPTH));
      end
      ar = AReady;
      tick();
      if (ar) acc++;
      total++;
      if (RegWrite !== 1'b0) begin
        bad++;
        $display("FAIL bp_stalled%0d: got we=%b want 0", i, RegWrite);
      end
    end
    AValid = 0;
    total++;
    if (acc !== DEPTH || Busy !== 1'b1) begin
      bad++;
      $display("FAIL bp_held: got accepted=%0d busy=%b want %0d/1", acc, Busy, DEPTH);
    end
    Stall = 0;
    for (int j = 0; j < DEPTH; j++) begin
      tick();
      total++;
      if (RegWrite !== 1'b1 || WriteRegister !== 5'd7 || WriteData !== 64'hC0 + 64'(j)) begin
        bad++;
        $display("FAIL bp_drain%0d: got we=%b reg=%0d data=%h want 1/7/%h", j, RegWrite, WriteRegister, WriteData, 64'hC0 + 64'(j));
      end
    end
    tick();
    total++;
    if (RegWrite !== 1'b0 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_idle: got we=%b busy=%b want 0/0", RegWrite, Busy);
    end
  endtask

  task automatic test_x31();
    AValid = 1; AReg = 5'd31; AData = 64'hA0;
    tick();
    AValid = 0;
    total++;
    if (Busy !== 1'b1 || RegWrite !== 1'b0) begin
      bad++;
      $display("FAIL x31_queued: got busy=%b we=%b want 1/0", Busy, RegWrite);
    end
    tick();
    total++;
    if (RegWrite !== 1'b0 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL x31_consumed: got we=%b busy=%b want 0/0", RegWrite, Busy);
    end
    total++;
    if (WriteRegister !== 5'd31 || WriteData !== 64'hA0) begin
      bad++;
      $display("FAIL x31_port: got reg=%0d data=%h want 31/a0", WriteRegister, WriteData);
    end
  endtask

  task automatic test_reset_mid();
    Stall = 1;
    for (int i = 0; i < 2; i++) begin
      AValid = 1; AReg = 5'(8 + i);  AData = 64'hD0 + 64'(i);
      BValid = 1; BReg = 5'(10 + i); BData = 64'hE0 + 64'(i);
      tick();
    end
    AValid = 0; BValid = 0;
    total++;
    if (AReady !== 1'b0 || BReady !== 1'b0 || Busy !== 1'b1) begin
      bad++;
      $display("FAIL rmid_full: got ar=%b br=%b busy=%b want 0/0/1", AReady, BReady, Busy);
    end
    rst_n = 0;
    #1;
    total++;
    if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 || WriteData !== 64'd0 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL rmid_clear: got we=%b reg=%0d data=%h busy=%b want 0/0/0/0", RegWrite, WriteRegister, WriteData, Busy);
    end
    total++;
    if (AReady !== 1'b1 || BReady !== 1'b1) begin
      bad++;
      $display("FAIL rmid_ready: got ar=%b br=%b want 1/1", AReady, BReady);
    end
    #2;
    rst_n = 1;
    Stall = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (RegWrite !== 1'b0 || Busy !== 1'b0) begin
        bad++;
        $display("FAIL rmid_after%0d: got we=%b busy=%b want 0/0", i, RegWrite, Busy);
      end
    end
  endtask

  task automatic test_regfile();
    AValid = 1; AReg = 5'd12; AData = 64'hAAAA;
    tick();
    AData = 64'hBBBB;
    tick();
    AValid = 0;
    total++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd12 || WriteData !== 64'hAAAA) begin
      bad++;
      $display("FAIL rf_port1: got we=%b reg=%0d data=%h want 1/12/aaaa", RegWrite, WriteRegister, WriteData);
    end
    tick();
    total++;
    if (rf[12] !== 64'hAAAA || RegWrite !== 1'b1 || WriteData !== 64'hBBBB) begin
      bad++;
      $display("FAIL rf_mid: got rf12=%h we=%b data=%h want aaaa/1/bbbb", rf[12], RegWrite, WriteData);
    end
    tick();
    total++;
    if (rf[12] !== 64'hBBBB) begin
      bad++;
      $display("FAIL rf_final: got rf12=%h want bbbb", rf[12]);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'd0;
    rst_n = 0; Stall = 0;
    AValid = 0; AReg = '0; AData = '0;
    BValid = 0; BReg = '0; BData = '0;
    test_reset();
    test_tie();
    test_fairness();
    test_backpressure();
    test_x31();
    test_reset_mid();
    test_regfile();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning entries per requester FIFO (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports AValid/BValid  input  1  requester A/B write request valid.
REQ-005 SHALL have ports AReg/BReg  input  5  destination register for A/B.
REQ-006 SHALL have ports AData/BData  input  64  write data for A/B.
REQ-007 SHALL have ports AReady/BReady  output  1  requester FIFO can accept an entry.
REQ-008 SHALL have port Stall  input  1  when 1, no FIFO entry is dequeued this cycle.
REQ-009 SHALL have port RegWrite  output  1  register-file write enable, registered.
REQ-010 SHALL have port WriteRegister  output  5  register-file write address, registered.
REQ-011 SHALL have port WriteData  output  64  register-file write data, registered.
REQ-012 SHALL have port Busy  output  1  1 when either FIFO is non-empty or RegWrite=1.

Function
REQ-013 SHALL enqueue {Reg,Data} into requester X's FIFO at a posedge where XValid=1 and XReady=1; otherwise the request is not taken.
REQ-014 SHALL drive XReady = NOT full(FIFO X), combinationally from the stored count only; no pass-through when full, even if a dequeue occurs in the same cycle.
REQ-015 SHALL preserve FIFO order within each requester; no entry dropped or duplicated.
REQ-016 SHALL, each cycle with Stall=0 and at least one FIFO non-empty, select one head: if only one FIFO is non-empty it wins; if both, the requester not equal to LastGrant wins (round-robin).
REQ-017 SHALL dequeue the winner's head at the posedge and load WriteRegister/WriteData from it at that posedge, updating LastGrant to the winner.
REQ-018 SHALL set RegWrite=1 at that posedge unless the dequeued register is 31, in which case RegWrite=0 (entry consumed, write suppressed; X31 is hardwired zero).
REQ-019 SHALL set RegWrite=0 at any posedge with no dequeue (Stall=1 or both empty); WriteRegister/WriteData hold their previous values.
REQ-020 SHALL give latency: entry enqueued at edge N into an empty FIFO and winning arbitration appears on the write port after edge N+1; the register file commits it at edge N+2.
REQ-021 SHALL support simultaneous enqueue and dequeue on the same FIFO in one cycle (count unchanged) when not full.
REQ-022 SHALL wrap FIFO read/write pointers modulo DEPTH; count ranges 0..DEPTH.
REQ-023 SHALL define cross-requester ordering to the same register solely by grant order; no hazard reordering.
REQ-024 SHALL achieve sustained throughput of one write per cycle when Stall=0 and entries are available.

Reset
REQ-025 SHALL, on rst_n=0 asynchronously: empty both FIFOs (pointers, counts 0), RegWrite=0, WriteRegister=0, WriteData=0, LastGrant=B, so AReady=BReady=1 and Busy=0 while asserted.
REQ-026 SHALL discard all queued entries and any in-flight output when reset asserts mid-operation; no write issues for them after release.
REQ-027 SHALL accept requests at the first posedge after rst_n deasserts.

Verification
REQ-028 SHALL verify tie: after reset, A (reg 3, 0x11) and B (reg 4, 0x22) enqueued same edge -> next two cycles RegWrite=1 with reg 3/0x11 then reg 4/0x22.
REQ-029 SHALL verify fairness: A and B each continuously valid for 8 requests -> write port alternates A,B,A,B..., 16 writes in 16 consecutive cycles.
REQ-030 SHALL verify backpressure: Stall=1, A sends DEPTH+1 requests -> AReady=0 after DEPTH accepted, RegWrite stays 0; Stall=0 -> DEPTH writes in FIFO order.
REQ-031 SHALL verify X31: A writes reg 31 data 0xA0 -> entry consumed, RegWrite=0 that cycle, Busy falls to 0.
REQ-032 SHALL verify reset mid-operation: both FIFOs holding 2 entries, pulse rst_n low -> all outputs 0 immediately, no writes after release, Busy=0.
REQ-033 SHALL verify end-to-end with regfile attached: same-requester writes 0xAAAA then 0xBBBB to reg 12 -> reg 12 reads 0xBBBB.
